// File: rtl/neocore_pkg.sv
// neocore_pkg: shared opcode encoding and helpers for the neocore execute stage.
//   opcode_e      - instruction opcodes seen by execute-stage units
//   is_branch_op  - true for any opcode resolved by branch_resolve_unit
package neocore_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_LD  = 4'd3,
        OP_ST  = 4'd4,
        OP_B   = 4'd5,
        OP_BE  = 4'd6,
        OP_BNE = 4'd7,
        OP_BLT = 4'd8,
        OP_BGT = 4'd9,
        OP_BRO = 4'd10,
        OP_JSR = 4'd11,
        OP_RTS = 4'd12
    } opcode_e;

    function automatic logic is_branch_op(opcode_e op);
        case (op)
            OP_B, OP_BE, OP_BNE, OP_BLT, OP_BGT,
            OP_BRO, OP_JSR, OP_RTS: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_ras.sv
// branch_ras: circular return-address stack.
//   clk, rst      - clock, asynchronous active-low reset
//   push          - write push_data as the new top (wraps over oldest when full)
//   pop           - drop the top entry (ignored when empty)
//   clear         - empty the stack; applied before a same-cycle push
//   push_data     - return address to push
//   top           - current top-of-stack entry
//   empty, full   - occupancy status
module branch_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [PW-1:0]     tos, tos_n, tos_base;
    logic [PW:0]       cnt, cnt_n, cnt_base;
    logic [ADDR_W-1:0] mem [RAS_DEPTH];

    // Clear is folded in first so a same-cycle push lands on an empty stack.
    assign tos_base = clear ? '0 : tos;
    assign cnt_base = clear ? '0 : cnt;

    always_comb begin
        tos_n = tos_base;
        cnt_n = cnt_base;
        if (push) begin
            // Pointer wraps naturally (depth is a power of two); when full the
            // new top lands on the oldest slot and the count stays saturated.
            tos_n = tos_base + 1'b1;
            cnt_n = (cnt_base == DEPTH_C) ? cnt_base : cnt_base + 1'b1;
        end else if (pop && cnt_base != '0) begin
            tos_n = tos_base - 1'b1;
            cnt_n = cnt_base - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos <= '0;
            cnt <= '0;
        end else begin
            tos <= tos_n;
            cnt <= cnt_n;
        end
    end

    // Storage needs no reset: count gates every read of meaningful data.
    always_ff @(posedge clk) begin
        if (push) mem[tos_n] <= push_data;
    end

    assign top   = mem[tos];
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined branch resolver with return-address stack.
//   clk, rst                 - clock, asynchronous active-low reset
//   in_valid/in_ready        - request handshake (single output register,
//                              pass-through ready)
//   opcode, operand_a/b      - instruction and compare operands
//   v_flag_in                - overflow flag for BRO
//   branch_target, return_pc - target for B/Bcc/JSR, return address for JSR
//   ras_clear                - empty the return-address stack
//   out_valid/out_ready      - result handshake
//   branch_taken, branch_pc  - redirect decision and address (0 if not taken)
//   ras_overflow/underflow   - result-aligned stack status for JSR/RTS
module branch_resolve_unit
    import neocore_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 32,
    parameter int RAS_DEPTH  = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  opcode_e           opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              v_flag_in,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] return_pc,
    input  logic              ras_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_pc,
    output logic              ras_overflow,
    output logic              ras_underflow
);
    logic              accept;
    logic              a_lt_b, a_gt_b;
    logic              taken_c, ovf_c, unf_c;
    logic [ADDR_W-1:0] pc_c;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full;
    logic              ras_push, ras_pop;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    if (SIGNED_CMP) begin : g_scmp
        assign a_lt_b = $signed(operand_a) < $signed(operand_b);
        assign a_gt_b = $signed(operand_a) > $signed(operand_b);
    end else begin : g_ucmp
        assign a_lt_b = operand_a < operand_b;
        assign a_gt_b = operand_a > operand_b;
    end

    // Result is computed from the pre-update stack, so an RTS with a
    // same-cycle ras_clear still sees the old top.
    always_comb begin
        taken_c = 1'b0;
        pc_c    = '0;
        ovf_c   = 1'b0;
        unf_c   = 1'b0;
        if (is_branch_op(opcode)) begin
            case (opcode)
                OP_B:    taken_c = 1'b1;
                OP_BE:   taken_c = (operand_a == operand_b);
                OP_BNE:  taken_c = (operand_a != operand_b);
                OP_BLT:  taken_c = a_lt_b;
                OP_BGT:  taken_c = a_gt_b;
                OP_BRO:  taken_c = v_flag_in;
                OP_JSR: begin
                    taken_c = 1'b1;
                    ovf_c   = ras_full && !ras_clear;
                end
                OP_RTS: begin
                    taken_c = !ras_empty;
                    unf_c   = ras_empty;
                end
                default: taken_c = 1'b0;
            endcase
            if (taken_c) pc_c = (opcode == OP_RTS) ? ras_top : branch_target;
        end
    end

    // Stack moves only on accept; a stalled request leaves it untouched.
    assign ras_push = accept && (opcode == OP_JSR);
    assign ras_pop  = accept && (opcode == OP_RTS);

    branch_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (return_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            branch_taken  <= 1'b0;
            branch_pc     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            branch_taken  <= taken_c;
            branch_pc     <= pc_c;
            ras_overflow  <= ovf_c;
            ras_underflow <= unf_c;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    import neocore_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    opcode_e     opcode = OP_NOP;
    logic [15:0] op_a = '0, op_b = '0;
    logic        v_flag = 1'b0;
    logic [31:0] tgt = '0, rpc = '0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_u, out_valid_u, taken_u, ovf_u, unf_u;
    logic [31:0] pc_u;
    logic        in_ready_s, out_valid_s, taken_s, ovf_s, unf_s;
    logic [31:0] pc_s;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DATA_W(16), .ADDR_W(32), .RAS_DEPTH(DEPTH), .SIGNED_CMP(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .opcode(opcode),
        .operand_a(op_a), .operand_b(op_b), .v_flag_in(v_flag), .branch_target(tgt),
        .return_pc(rpc), .ras_clear(clr), .out_valid(out_valid_u), .out_ready(out_ready),
        .branch_taken(taken_u), .branch_pc(pc_u), .ras_overflow(ovf_u), .ras_underflow(unf_u));

    branch_resolve_unit #(.DATA_W(16), .ADDR_W(32), .RAS_DEPTH(DEPTH), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .opcode(opcode),
        .operand_a(op_a), .operand_b(op_b), .v_flag_in(v_flag), .branch_target(tgt),
        .return_pc(rpc), .ras_clear(clr), .out_valid(out_valid_s), .out_ready(out_ready),
        .branch_taken(taken_s), .branch_pc(pc_s), .ras_overflow(ovf_s), .ras_underflow(unf_s));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: stack as a queue, newest at the back.
    logic [31:0] ref_q[$];

    typedef struct {
        logic        tk_u, tk_s;
        logic [31:0] pc_u, pc_s;
        logic        ovf, unf;
    } exp_t;

    task automatic model_step(input opcode_e op, input logic [15:0] a, input logic [15:0] b,
                              input logic v, input logic [31:0] t, input logic [31:0] r,
                              input logic c, output exp_t e);
        int pre;
        pre = ref_q.size();
        e = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
        case (op)
            OP_B:   begin e.tk_u = 1; e.tk_s = 1; end
            OP_BE:  begin e.tk_u = (a == b); e.tk_s = (a == b); end
            OP_BNE: begin e.tk_u = (a != b); e.tk_s = (a != b); end
            OP_BLT: begin e.tk_u = (a < b); e.tk_s = ($signed(a) < $signed(b)); end
            OP_BGT: begin e.tk_u = (a > b); e.tk_s = ($signed(a) > $signed(b)); end
            OP_BRO: begin e.tk_u = v; e.tk_s = v; end
            OP_JSR: begin e.tk_u = 1; e.tk_s = 1; e.ovf = (!c && pre == DEPTH); end
            OP_RTS: begin e.tk_u = (pre > 0); e.tk_s = (pre > 0); e.unf = (pre == 0); end
            default: ;
        endcase
        if (op == OP_RTS) begin
            if (pre > 0) begin e.pc_u = ref_q[pre-1]; e.pc_s = ref_q[pre-1]; end
        end else begin
            e.pc_u = e.tk_u ? t : 32'h0;
            e.pc_s = e.tk_s ? t : 32'h0;
        end
        if (c) ref_q.delete();
        if (op == OP_JSR) begin
            ref_q.push_back(r);
            if (ref_q.size() > DEPTH) void'(ref_q.pop_front());
        end else if (op == OP_RTS && !c && pre > 0) begin
            void'(ref_q.pop_back());
        end
    endtask

    // One accepted request; outputs sampled 1 time unit after the accepting edge.
    task automatic do_op(input opcode_e op, input logic [15:0] a, input logic [15:0] b,
                         input logic v, input logic [31:0] t, input logic [31:0] r,
                         input logic c, output exp_t e);
        @(negedge clk);
        opcode = op; op_a = a; op_b = b; v_flag = v; tgt = t; rpc = r; clr = c;
        in_valid = 1'b1; out_ready = 1'b1;
        model_step(op, a, b, v, t, r, c, e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        chk({tag, ".valid"}, {31'h0, out_valid_u}, 32'h1);
        chk({tag, ".taken_u"}, {31'h0, taken_u}, {31'h0, e.tk_u});
        chk({tag, ".pc_u"}, pc_u, e.pc_u);
        chk({tag, ".taken_s"}, {31'h0, taken_s}, {31'h0, e.tk_s});
        chk({tag, ".pc_s"}, pc_s, e.pc_s);
        chk({tag, ".ovf"}, {31'h0, ovf_u}, {31'h0, e.ovf});
        chk({tag, ".unf"}, {31'h0, unf_u}, {31'h0, e.unf});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        opcode_e     op;
        logic [15:0] a, b;
        logic        v;
        logic [31:0] t, r;
        logic        c;
        logic        tk_u, tk_s;
        logic [31:0] pc_u, pc_s;
        logic        ovf, unf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        exp_t e;
        opcode_e ops[10];

        tbl[0]  = '{OP_BE,  16'h1234, 16'h1234, 1'b0, 32'h2000, 32'h0,   1'b0, 1, 1, 32'h2000, 32'h2000, 0, 0};
        tbl[1]  = '{OP_BLT, 16'hFFFF, 16'h0001, 1'b0, 32'h3000, 32'h0,   1'b0, 0, 1, 32'h0,    32'h3000, 0, 0};
        tbl[2]  = '{OP_BGT, 16'hFFFF, 16'h0001, 1'b0, 32'h3100, 32'h0,   1'b0, 1, 0, 32'h3100, 32'h0,    0, 0};
        tbl[3]  = '{OP_BRO, 16'h0000, 16'h0000, 1'b1, 32'h3200, 32'h0,   1'b0, 1, 1, 32'h3200, 32'h3200, 0, 0};
        tbl[4]  = '{OP_ADD, 16'h0001, 16'h0001, 1'b1, 32'h3300, 32'h0,   1'b0, 0, 0, 32'h0,    32'h0,    0, 0};
        tbl[5]  = '{OP_JSR, 16'h0000, 16'h0000, 1'b0, 32'h0500, 32'h100, 1'b0, 1, 1, 32'h0500, 32'h0500, 0, 0};
        tbl[6]  = '{OP_JSR, 16'h0000, 16'h0000, 1'b0, 32'h0600, 32'h200, 1'b0, 1, 1, 32'h0600, 32'h0600, 0, 0};
        tbl[7]  = '{OP_RTS, 16'h0000, 16'h0000, 1'b0, 32'h0,    32'h0,   1'b0, 1, 1, 32'h0200, 32'h0200, 0, 0};
        tbl[8]  = '{OP_RTS, 16'h0000, 16'h0000, 1'b0, 32'h0,    32'h0,   1'b0, 1, 1, 32'h0100, 32'h0100, 0, 0};
        tbl[9]  = '{OP_RTS, 16'h0000, 16'h0000, 1'b0, 32'h0,    32'h0,   1'b0, 0, 0, 32'h0,    32'h0,    0, 1};
        tbl[10] = '{OP_BNE, 16'h0005, 16'h0005, 1'b0, 32'h3400, 32'h0,   1'b0, 0, 0, 32'h0,    32'h0,    0, 0};

        // Reset state
        #3;
        chk("rst.in_ready", {31'h0, in_ready_u}, 32'h1);
        chk("rst.out_valid", {31'h0, out_valid_u}, 32'h0);
        chk("rst.taken", {31'h0, taken_u}, 32'h0);
        chk("rst.pc", pc_u, 32'h0);
        chk("rst.flags", {30'h0, ovf_u, unf_u}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].t, tbl[i].r, tbl[i].c, e);
            chk($sformatf("tbl%0d.valid", i), {31'h0, out_valid_u}, 32'h1);
            chk($sformatf("tbl%0d.in_ready", i), {31'h0, in_ready_u}, 32'h1);
            chk($sformatf("tbl%0d.taken_u", i), {31'h0, taken_u}, {31'h0, tbl[i].tk_u});
            chk($sformatf("tbl%0d.taken_s", i), {31'h0, taken_s}, {31'h0, tbl[i].tk_s});
            chk($sformatf("tbl%0d.pc_u", i), pc_u, tbl[i].pc_u);
            chk($sformatf("tbl%0d.pc_s", i), pc_s, tbl[i].pc_s);
            chk($sformatf("tbl%0d.ovf", i), {31'h0, ovf_u}, {31'h0, tbl[i].ovf});
            chk($sformatf("tbl%0d.unf", i), {31'h0, unf_u}, {31'h0, tbl[i].unf});
        end

        // Overflow: 9 JSRs then 8 RTS
        for (int i = 1; i <= 9; i++) begin
            do_op(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h8000 + i, i, 1'b0, e);
            chk($sformatf("ovf.jsr%0d", i), {31'h0, ovf_u}, (i == 9) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
            chk($sformatf("ovf.rts%0d.pc", k), pc_u, 32'(9 - k));
            chk($sformatf("ovf.rts%0d.taken", k), {31'h0, taken_u}, 32'h1);
        end
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("ovf.drained.unf", {31'h0, unf_u}, 32'h1);

        // Back-pressure: held JSR must not push until accepted
        do_reset();
        do_op(OP_B, 16'h0, 16'h0, 1'b0, 32'h4000, 32'h0, 1'b0, e);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = OP_JSR; tgt = 32'h5000; rpc = 32'h777;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.valid", c), {31'h0, out_valid_u}, 32'h1);
            chk($sformatf("stall%0d.pc", c), pc_u, 32'h4000);
            chk($sformatf("stall%0d.taken", c), {31'h0, taken_u}, 32'h1);
            chk($sformatf("stall%0d.in_ready", c), {31'h0, in_ready_u}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        model_step(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h5000, 32'h777, 1'b0, e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall.jsr.pc", pc_u, 32'h5000);
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("stall.rts.pc", pc_u, 32'h777);
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("stall.rts2.unf", {31'h0, unf_u}, 32'h1);

        // Clear with JSR, then clear with RTS
        do_op(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h10, 32'h111, 1'b0, e);
        do_op(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h20, 32'h300, 1'b1, e);
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("clr.jsr.rts.pc", pc_u, 32'h300);
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("clr.jsr.rts2.unf", {31'h0, unf_u}, 32'h1);
        do_op(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h30, 32'h444, 1'b0, e);
        do_op(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h40, 32'h555, 1'b0, e);
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b1, e);
        chk("clr.rts.pc", pc_u, 32'h555);
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("clr.rts.after.unf", {31'h0, unf_u}, 32'h1);

        // Reset mid-stream
        do_op(OP_JSR, 16'h0, 16'h0, 1'b0, 32'h50, 32'h666, 1'b0, e);
        #2;
        rst = 1'b0;
        ref_q.delete();
        #1;
        chk("midrst.out_valid", {31'h0, out_valid_u}, 32'h0);
        chk("midrst.taken", {31'h0, taken_u}, 32'h0);
        chk("midrst.in_ready", {31'h0, in_ready_u}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        do_op(OP_RTS, 16'h0, 16'h0, 1'b0, 32'h0, 32'h0, 1'b0, e);
        chk("midrst.rts.unf", {31'h0, unf_u}, 32'h1);
        chk("midrst.rts.taken", {31'h0, taken_u}, 32'h0);

        // Randomized against the reference model
        ops = '{OP_NOP, OP_B, OP_BE, OP_BNE, OP_BLT, OP_BGT, OP_BRO, OP_JSR, OP_RTS, OP_ADD};
        for (int n = 0; n < 400; n++) begin
            opcode_e     op;
            logic [15:0] a, b;
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 0) begin
                a = 16'($urandom_range(0, 3)); b = 16'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) begin a = ~a; end
            end else begin
                a = 16'($urandom); b = 16'($urandom);
            end
            do_op(op, a, b, 1'($urandom), $urandom, $urandom, ($urandom_range(0, 15) == 0), e);
            check_exp($sformatf("rnd%0d", n), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
